// File: rtl/mac_array_engine.sv
// Row-sequential MAC engine: N_OUT dot products of a latched input vector against a row-major weight BRAM.
// Define MAC_SATURATE_EN to clamp results to OUT_W; otherwise results wrap.
module mac_array_engine #(
    parameter int N_IN    = 16,
    parameter int N_OUT   = 8,
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 40,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 8,
    parameter int RAM_LAT = 2,
    parameter int ADDR_W  = 7,
    localparam int RW     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic [N_IN*DATA_W-1:0]   input_vec,
    output logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    output logic                     busy,
    output logic [OUT_W-1:0]         out_data,
    output logic [RW-1:0]            out_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done
);
    localparam int CW = $clog2(N_IN + RAM_LAT + 2);
    localparam int IW = $clog2(N_IN);
    localparam logic [CW-1:0] C_ISSUE_LAST = CW'(N_IN - 1);
    localparam logic [CW-1:0] C_LAST       = CW'(N_IN + RAM_LAT + 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, OUT, FIN} state_t;

    state_t                      state, state_d;
    logic [N_IN-1:0][DATA_W-1:0] vec_q;
    logic                        relu_q;
    logic [CW-1:0]               c;
    logic [RW-1:0]               row;
    logic [RAM_LAT:0]            vld_pipe;
    logic signed [2*DATA_W-1:0]  prod;
    logic signed [ACC_W-1:0]     acc;
    logic                        issue;
    logic signed [DATA_W-1:0]    elem;

    // vld_pipe[k] marks an address issued k+1 cycles ago; data lands at RAM_LAT-1, product at RAM_LAT.
    assign issue = (state == RUN) && (c <= C_ISSUE_LAST);
    assign elem  = vec_q[IW'(c - CW'(RAM_LAT))];
    assign busy  = (state == RUN) || (state == OUT);
    assign done  = (state == FIN);

    function automatic logic [OUT_W-1:0] narrow(input logic signed [ACC_W-1:0] a, input logic relu);
        logic signed [ACC_W-1:0] r;
        r = a >>> SHIFT;
        if (relu && r < 0)
            r = '0;
`ifdef MAC_SATURATE_EN
        if (r > SAT_MAX)
            r = SAT_MAX;
        else if (r < SAT_MIN)
            r = SAT_MIN;
`endif
        narrow = r[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (c == C_LAST) state_d = OUT;
            OUT:     if (out_ready) state_d = (row == ROW_LAST) ? FIN : RUN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q     <= '0;
            relu_q    <= 1'b0;
            c         <= '0;
            row       <= '0;
            vld_pipe  <= '0;
            prod      <= '0;
            acc       <= '0;
            w_addr    <= '0;
            out_data  <= '0;
            out_row   <= '0;
            out_valid <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[RAM_LAT-1:0], issue};
            if (vld_pipe[RAM_LAT-1])
                prod <= $signed(w_data) * elem;
            if (vld_pipe[RAM_LAT])
                acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
            case (state)
                IDLE: if (start) begin
                    vec_q  <= input_vec;
                    relu_q <= relu_en;
                    row    <= '0;
                    c      <= '0;
                    acc    <= '0;
                    w_addr <= '0;
                end
                RUN: begin
                    c <= c + 1'b1;
                    if (c < C_ISSUE_LAST)
                        w_addr <= w_addr + 1'b1;
                    // Pipeline fully drained here, so acc holds the complete row sum.
                    if (c == C_LAST) begin
                        out_data  <= narrow(acc, relu_q);
                        out_row   <= row;
                        out_valid <= 1'b1;
                    end
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    acc       <= '0;
                    c         <= '0;
                    if (row != ROW_LAST) begin
                        row    <= row + 1'b1;
                        w_addr <= w_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_array_engine.sv
// Directed bench for mac_array_engine: vector table on a 16x8 instance plus an N_IN=4, RAM_LAT=3 instance.
module tb_mac_array_engine;
    localparam int NI = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // instance A: defaults except SHIFT=0
    logic           a_start = 1'b0, a_relu = 1'b0, a_ready = 1'b1;
    logic [NI*DW-1:0] a_in = '0;
    logic [6:0]     a_addr;
    logic [15:0]    a_wdata;
    logic           a_busy, a_valid, a_done;
    logic [15:0]    a_data;
    logic [2:0]     a_row;
    logic [15:0]    mem_a [0:127];
    logic [15:0]    pa [0:1];

    always @(posedge clk) begin
        pa[0] <= mem_a[a_addr];
        pa[1] <= pa[0];
    end
    assign a_wdata = pa[1];

    mac_array_engine #(.N_IN(16), .N_OUT(8), .DATA_W(16), .ACC_W(40), .OUT_W(16),
                       .SHIFT(0), .RAM_LAT(2), .ADDR_W(7)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .relu_en(a_relu), .input_vec(a_in),
        .w_addr(a_addr), .w_data(a_wdata), .busy(a_busy), .out_data(a_data),
        .out_row(a_row), .out_valid(a_valid), .out_ready(a_ready), .done(a_done));

    // instance B: N_IN=4, RAM_LAT=3, two rows
    logic           b_start = 1'b0, b_relu = 1'b0, b_ready = 1'b1;
    logic [4*DW-1:0] b_in = '0;
    logic [6:0]     b_addr;
    logic [15:0]    b_wdata;
    logic           b_busy, b_valid, b_done;
    logic [15:0]    b_data;
    logic [0:0]     b_row;
    logic [15:0]    mem_b [0:127];
    logic [15:0]    pb [0:2];

    always @(posedge clk) begin
        pb[0] <= mem_b[b_addr];
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign b_wdata = pb[2];

    mac_array_engine #(.N_IN(4), .N_OUT(2), .DATA_W(16), .ACC_W(40), .OUT_W(16),
                       .SHIFT(0), .RAM_LAT(3), .ADDR_W(7)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .relu_en(b_relu), .input_vec(b_in),
        .w_addr(b_addr), .w_data(b_wdata), .busy(b_busy), .out_data(b_data),
        .out_row(b_row), .out_valid(b_valid), .out_ready(b_ready), .done(b_done));

    // weight[r][c] = wa*r + wb; input elem i = inc ? i+1 : in_c
    typedef struct {
        int wa;
        int wb;
        bit inc;
        int in_c;
        bit relu;
        int expv[8];
    } vec_t;
    vec_t tv[6];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic setv(input int i, input int wa, input int wb, input bit inc, input int in_c, input bit relu);
        tv[i].wa = wa; tv[i].wb = wb; tv[i].inc = inc; tv[i].in_c = in_c; tv[i].relu = relu;
    endtask

    task automatic load_a(input int vi);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                mem_a[r*16+c] = 16'(tv[vi].wa * r + tv[vi].wb);
        for (int i = 0; i < NI; i++)
            a_in[i*DW +: DW] = tv[vi].inc ? 16'(i + 1) : 16'(tv[vi].in_c);
        a_relu = tv[vi].relu;
    endtask

    task automatic run_vec(input int vi, input int stall_row, input bit poke);
        int cyc, nrows;
        bit done_seen;
        load_a(vi);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_in = {NI{16'h5a5a}};
        a_relu = ~tv[vi].relu;
        cyc = 0; nrows = 0; done_seen = 0;
        while (!done_seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (poke) a_start = (cyc == 25);
            if (cyc == 1) chk("busy_run", a_busy, 1);
            if (a_valid) begin
                if (nrows == 0) chk("latency", cyc, 20);
                chk("out_row", a_row, nrows);
                chk("out_data", $signed(a_data), (nrows < 8) ? tv[vi].expv[nrows] : 0);
                if (a_row == stall_row) begin
                    a_ready = 1'b0;
                    for (int k = 0; k < 7; k++) begin
                        @(negedge clk);
                        cyc++;
                        chk("stall_valid", a_valid, 1);
                        chk("stall_row", a_row, stall_row);
                        chk("stall_data", $signed(a_data), tv[vi].expv[stall_row]);
                        chk("stall_addr", a_addr, stall_row*16 + 15);
                    end
                    a_ready = 1'b1;
                    @(negedge clk);
                    cyc++;
                    chk("post_hs_valid", a_valid, 0);
                    chk("post_hs_addr", a_addr, (stall_row + 1)*16);
                end
                nrows++;
            end
            if (a_done) begin
                chk("rows_at_done", nrows, 8);
                chk("busy_at_done", a_busy, 0);
                done_seen = 1;
            end
        end
        a_start = 1'b0;
        chk("done_seen", done_seen, 1);
        @(negedge clk);
        chk("done_width", a_done, 0);
    endtask

    task automatic run_reset();
        int cyc, spurious;
        bit seen3;
        load_a(0);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        cyc = 0; seen3 = 0;
        while (!seen3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (a_valid && a_row == 3'd3) seen3 = 1;
        end
        chk("reach_row3", seen3, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", a_valid, 0);
        chk("rst_data", a_data, 0);
        chk("rst_row", a_row, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        rst = 1'b0;
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_done || a_valid || a_busy) spurious++;
        end
        chk("no_activity_after_rst", spurious, 0);
    endtask

    task automatic run_b();
        int k, rows;
        bit bdone;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                mem_b[r*4+c] = (r == 0) ? 16'd1 : 16'(c + 1);
        for (int i = 0; i < 4; i++)
            b_in[i*DW +: DW] = 16'(i + 1);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        k = 0; rows = 0; bdone = 0;
        while (!bdone && k < 100) begin
            if (k <= 5) chk("b_waddr", b_addr, (k < 3) ? k : 3);
            if (k == 10) chk("b_waddr_row1_first", b_addr, 4);
            if (k == 13) chk("b_waddr_row1_last", b_addr, 7);
            if (b_valid) begin
                if (rows == 0) chk("b_latency", k, 9);
                chk("b_row", b_row, rows);
                chk("b_data", $signed(b_data), (rows == 0) ? 10 : 30);
                rows++;
            end
            if (b_done) bdone = 1;
            @(negedge clk);
            k++;
        end
        chk("b_rows", rows, 2);
        chk("b_done_seen", bdone, 1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        setv(0, 0, 1, 1, 0, 0);          tv[0].expv = '{8{136}};
        setv(1, -1, -1, 0, 2, 0);        tv[1].expv = '{-32, -64, -96, -128, -160, -192, -224, -256};
        setv(2, -1, -1, 0, 2, 1);        tv[2].expv = '{8{0}};
        setv(3, 0, 32767, 0, 32767, 0);
        setv(4, 1, -3, 0, 1, 1);         tv[4].expv = '{0, 0, 0, 0, 16, 32, 48, 64};
        setv(5, 0, -32768, 0, 32767, 0);
`ifdef MAC_SATURATE_EN
        tv[3].expv = '{8{32767}};
        tv[5].expv = '{8{-32768}};
`else
        tv[3].expv = '{8{16}};
        tv[5].expv = '{8{0}};
`endif

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_valid", a_valid, 0);
        chk("reset_data", a_data, 0);
        chk("reset_row", a_row, 0);
        chk("reset_addr", a_addr, 0);
        chk("reset_busy", a_busy, 0);
        chk("reset_done", a_done, 0);
        chk("reset_b_addr", b_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int vi = 0; vi < 6; vi++)
            run_vec(vi, -1, 1'b0);
        run_vec(0, 2, 1'b1);
        run_reset();
        run_vec(1, -1, 1'b0);
        run_b();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_array_engine.md
Name: mac_array_engine

Overview:
Parametrised successor to the single-row MAC engine. Computes N_OUT dot products of one latched input vector against a row-major weight BRAM, one row at a time. Each row goes through shift, optional ReLU and narrowing to OUT_W, then is streamed out on a valid/ready handshake. It sits between the input feature buffer and the activation/spike stage of the neural accelerator.

Parameters:
N_IN, 16, input vector length (elements per row), >=2
N_OUT, 8, number of output rows (neurons) per start
DATA_W, 16, signed input and weight width
ACC_W, 40, signed accumulator width; must be >= 2*DATA_W + clog2(N_IN)
OUT_W, 16, signed output width
SHIFT, 8, arithmetic right shift applied to the accumulator before narrowing
RAM_LAT, 2, weight BRAM read latency in cycles, >=1
ADDR_W, 7, weight address width; must be >= clog2(N_IN*N_OUT)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
relu_en  in  1  clamp negative results to 0; latched at start
input_vec  in  N_IN*DATA_W  signed elements; element i is bits [i*DATA_W +: DATA_W]; latched at start
w_addr  out  ADDR_W  registered weight address, row*N_IN + col
w_data  in  DATA_W  signed weight, valid RAM_LAT cycles after w_addr
busy  out  1  high from start acceptance until done
out_data  out  OUT_W  signed row result
out_row  out  clog2(N_OUT) (min 1)  row index of out_data
out_valid  out  1  result valid; held until accepted
out_ready  in  1  consumer accepts when out_valid&&out_ready
done  out  1  one-cycle pulse after last row accepted

Behaviour:
- Reset: state IDLE; w_addr, out_data, out_row, out_valid, busy, done, accumulator and counters all 0. Reset mid-operation abandons work with no done pulse.
- States: IDLE, RUN, OUT, FIN.
- IDLE:
  - start=1 at an edge: latch input_vec and relu_en, row=0, col=0, clear accumulator, busy=1, go to RUN.
  - start while not IDLE is ignored (no queuing).
- RUN: cycle counter c runs 0..N_IN+RAM_LAT-1.
  - w_addr = row*N_IN + c for c<N_IN, otherwise it holds its last value.
  - For c in [RAM_LAT, N_IN+RAM_LAT-1], accumulate acc += sext(w_data * elem[c-RAM_LAT]). The product is full 2*DATA_W signed, sign-extended to ACC_W. No wrap is possible given the ACC_W rule.
  - After the last accumulate: register out_data, set out_row=row, out_valid=1, go to OUT.
- Latency: with defaults, out_valid for row 0 rises on the 20th edge after the edge that sampled start (N_IN+RAM_LAT+2).
- Result path:
  - r = acc >>> SHIFT (arithmetic shift).
  - If relu_en and r<0, then r=0.
  - Narrow r to OUT_W per the Optional Feature.
- OUT:
  - out_data and out_row are stable while out_valid=1 and out_ready=0 (indefinite backpressure allowed).
  - On handshake: out_valid=0 next cycle and the accumulator is cleared.
  - If row<N_OUT-1: row++, go to RUN.
  - If row==N_OUT-1: go to FIN.
  - Rows are never overlapped; throughput is one row per N_IN+RAM_LAT+2 cycles with out_ready tied high.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. start is not accepted in FIN. It may be accepted on the cycle after done.
- out_ready while out_valid=0 is ignored.

Optional Feature:
MAC_SATURATE_EN
- Defined: r is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] before output.
- Undefined: out_data = r[OUT_W-1:0] (two's-complement wrap).
- ReLU is applied before narrowing in both cases.

Test Plan:
1. Defaults, all weights=1, input elem i = i+1, SHIFT=0, out_ready=1 -> every row gives out_data=136; rows 0..7 in order; out_valid rises 20 edges after start; done pulses once after row 7.
2. Row r weights = -(r+1), inputs all 2, relu_en=0 -> out_data = -32*(r+1). Repeat with relu_en=1 -> every out_data=0.
3. SHIFT=0, inputs and weights all 32767:
   - with MAC_SATURATE_EN -> out_data=32767 every row;
   - without -> out_data = low 16 bits of 16*32767^2 (0x0010).
4. Backpressure: out_ready=0 for 7 cycles at row 2 -> out_valid, out_data and out_row=2 held stable; w_addr does not advance to row 3 until the handshake.
5. start pulsed while busy -> ignored, results unchanged. rst asserted during RUN of row 4 -> next cycle all outputs 0, no done; a fresh start then completes normally.
6. RAM_LAT=3, N_IN=4 -> w_addr sequence row*4+0..3; the accumulate window is aligned so test-1 style data gives out_data=10.
